// File: rtl/booth_sched_pkg.sv
// Shared types and widths for the Booth multiplier scheduler.
package booth_sched_pkg;

  localparam int unsigned OP_W            = 16;
  localparam int unsigned PROD_W          = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_RESP,
    S_ABORT
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  always_comb begin
    int unsigned pos;
    logic [SW-1:0] sel;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(ptr) + k) % NREQ;
      sel = SW'(pos);
      if (!any && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = IDW'(pos);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mult_scheduler.sv
// Shares one start/done Booth multiplier among NREQ requesters with
// round-robin grant, a single response channel and timeout recovery.
module booth_mult_scheduler
  import booth_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned IDW     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [PROD_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic [OP_W-1:0]        mul_in1,
  output logic [OP_W-1:0]        mul_in2,
  output logic                   mul_start,
  output logic                   mul_rst,
  input  logic                   mul_done,
  input  logic [PROD_W-1:0]      mul_out
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cur_id;
  logic [TW-1:0]    timer;
  logic             abort_pulse;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any;
  logic [OP_W-1:0]  sel_a;
  logic [OP_W-1:0]  sel_b;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*OP_W +: OP_W];
        sel_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  assign req_ready = (state == S_IDLE && !rst) ? gnt : '0;
  assign mul_rst   = rst | abort_pulse;
  assign rsp_id    = cur_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      timer       <= '0;
      mul_in1     <= '0;
      mul_in2     <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_valid   <= 1'b0;
      mul_start   <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      mul_start   <= 1'b0;
      abort_pulse <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any) begin
            mul_in1   <= sel_a;
            mul_in2   <= sel_b;
            cur_id    <= gnt_idx;
            mul_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_ARM;
        // mul_done may still be asserted from the previous product here.
        S_ARM: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            rsp_data  <= mul_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_data    <= '0;
            rsp_err     <= 1'b1;
            abort_pulse <= 1'b1;
            state       <= S_ABORT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_ABORT: begin
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + IDW'(1);
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
